// File: rtl/register_file_nr_1w_be_clr.sv
// ---------------------------------------------------------------------------
// register_file_nr_1w_be_clr
//
// Purpose:
//   Shared scratch/descriptor register file for the FPGA build. It has
//   N_READ independent registered read ports and one byte-masked write port.
//   A read and a write to the same address in the same cycle return the newly
//   written bytes (write-first). A sequential clear engine zero-fills the whole
//   array after reset and on request. Storage has no per-bit reset, so it can
//   map onto BRAM/LUTRAM.
//
// Optional feature macro: REGFILE_PARITY_EN
//   Defined   : one even-parity bit is stored per byte. Each enabled read
//               recomputes the parity and registers parity_err_o[p].
//   Undefined : no parity storage is built, and parity_err_o is tied to 0.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset (FSM and read registers only)
//   clear_req_i   request a full-array zero fill (ignored while clearing)
//   clear_busy_o  clear engine active: writes are dropped, reads return 0
//   ReadEnable    per-port read strobe
//   ReadAddr      packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   ReadData      packed registered read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   WriteEnable   write strobe
//   WriteAddr     write address
//   WriteData     write data
//   WriteBE       byte enables, one per data byte
//   parity_err_o  per-port parity error, registered alongside ReadData
// ---------------------------------------------------------------------------
module register_file_nr_1w_be_clr #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int N_READ     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_req_i,
    output logic                         clear_busy_o,
    input  logic [N_READ-1:0]            ReadEnable,
    input  logic [N_READ*ADDR_WIDTH-1:0] ReadAddr,
    output logic [N_READ*DATA_WIDTH-1:0] ReadData,
    input  logic                         WriteEnable,
    input  logic [ADDR_WIDTH-1:0]        WriteAddr,
    input  logic [DATA_WIDTH-1:0]        WriteData,
    input  logic [DATA_WIDTH/8-1:0]      WriteBE,
    output logic [N_READ-1:0]            parity_err_o
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic                  we_eff;

    // ---------------- clear engine FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CLEAR: begin
                // The counter wraps to 0 on the last entry. That leaves it
                // ready for the next clear request.
                cnt_next = cnt_reg + ADDR_WIDTH'(1);
                if (&cnt_reg) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clear_req_i) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign clear_busy_o = (state_reg == CLEAR);
    assign we_eff       = WriteEnable && (state_reg == IDLE);

    // ---------------- storage ----------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
            mem[cnt_reg] <= '0;
        end else if (WriteEnable) begin
            for (int b = 0; b < NB; b++) begin
                if (WriteBE[b]) begin
                    mem[WriteAddr][b*8 +: 8] <= WriteData[b*8 +: 8];
                end
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    // Even parity per byte: the stored bit is the XOR of the byte, so a
    // zero-filled entry has all-zero parity.
    always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
            par_mem[cnt_reg] <= '0;
        end else if (WriteEnable) begin
            for (int b = 0; b < NB; b++) begin
                if (WriteBE[b]) begin
                    par_mem[WriteAddr][b] <= ^WriteData[b*8 +: 8];
                end
            end
        end
    end
`endif

    // ---------------- read ports ----------------
    genvar gi;
    generate
        for (gi = 0; gi < N_READ; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] raddr;
            logic [DATA_WIDTH-1:0] rd_fwd;
            logic [DATA_WIDTH-1:0] rdata_reg;

            assign raddr = ReadAddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

            // Write-first merge: bytes being written this cycle come from
            // WriteData, and the other bytes come from the stored entry.
            always_comb begin
                rd_fwd = mem[raddr];
                for (int b = 0; b < NB; b++) begin
                    if (we_eff && (WriteAddr == raddr) && WriteBE[b]) begin
                        rd_fwd[b*8 +: 8] = WriteData[b*8 +: 8];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg <= '0;
                end else if (ReadEnable[gi]) begin
                    rdata_reg <= clear_busy_o ? '0 : rd_fwd;
                end
            end

            assign ReadData[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_reg;

`ifdef REGFILE_PARITY_EN
            logic [NB-1:0] par_fwd;
            logic          perr_fwd;
            logic          perr_reg;

            // Forwarded bytes use freshly computed parity, so they can never
            // flag an error. Only bytes coming from storage are checked.
            always_comb begin
                par_fwd  = par_mem[raddr];
                perr_fwd = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    if (we_eff && (WriteAddr == raddr) && WriteBE[b]) begin
                        par_fwd[b] = ^WriteData[b*8 +: 8];
                    end
                    if ((^rd_fwd[b*8 +: 8]) != par_fwd[b]) begin
                        perr_fwd = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    perr_reg <= 1'b0;
                end else if (ReadEnable[gi]) begin
                    perr_reg <= clear_busy_o ? 1'b0 : perr_fwd;
                end
            end

            assign parity_err_o[gi] = perr_reg;
`else
            assign parity_err_o[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_register_file_nr_1w_be_clr.sv
module tb_register_file_nr_1w_be_clr;

`ifdef REGFILE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clear_req_i = 1'b0;
    logic         clear_busy_o;
    logic [1:0]   ReadEnable = '0;
    logic [9:0]   ReadAddr = '0;
    logic [127:0] ReadData;
    logic         WriteEnable = 1'b0;
    logic [4:0]   WriteAddr = '0;
    logic [63:0]  WriteData = '0;
    logic [7:0]   WriteBE = '0;
    logic [1:0]   parity_err_o;

    always #5 clk = ~clk;

    register_file_nr_1w_be_clr #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(64),
        .N_READ    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req_i (clear_req_i),
        .clear_busy_o(clear_busy_o),
        .ReadEnable  (ReadEnable),
        .ReadAddr    (ReadAddr),
        .ReadData    (ReadData),
        .WriteEnable (WriteEnable),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .WriteBE     (WriteBE),
        .parity_err_o(parity_err_o)
    );

    typedef struct {
        int          port;
        logic [63:0] data;
        logic        perr;
        bit          rd;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] ref_mem [32];
    logic [31:0] corrupt = '0;
    bit          m_clear = 1'b1;
    int          m_cnt = 0;
    logic [63:0] hold_d [2];
    logic        hold_p [2];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: build expectations from the pre-edge model and inputs, advance
    // the model, then compare just after the edge.
    task automatic step();
        exp_t        e;
        int          ra;
        logic [63:0] d;
        logic        pe;
        for (int p = 0; p < 2; p++) begin
            ra = int'(ReadAddr[p*5 +: 5]);
            e.rd = 1'b0;
            if (!rst_n) begin
                hold_d[p] = '0;
                hold_p[p] = 1'b0;
            end else if (ReadEnable[p]) begin
                e.rd = 1'b1;
                if (m_clear) begin
                    d  = '0;
                    pe = 1'b0;
                end else begin
                    d  = ref_mem[ra];
                    pe = corrupt[ra];
                    if (WriteEnable && int'(WriteAddr) == ra) begin
                        for (int b = 0; b < 8; b++)
                            if (WriteBE[b]) d[b*8 +: 8] = WriteData[b*8 +: 8];
                        if (WriteBE[0]) pe = 1'b0;
                    end
                end
                hold_d[p] = d;
                hold_p[p] = pe;
            end
            e.port = p;
            e.data = hold_d[p];
            e.perr = hold_p[p];
            sb_q.push_back(e);
        end
        if (rst_n && WriteEnable)
            $display("wr addr=%0d data=%h be=%h busy=%0d", WriteAddr, WriteData, WriteBE, m_clear);
        if (!rst_n) begin
            m_clear = 1'b1;
            m_cnt   = 0;
        end else if (m_clear) begin
            ref_mem[m_cnt] = '0;
            corrupt[m_cnt] = 1'b0;
            if (m_cnt == 31) m_clear = 1'b0;
            m_cnt = (m_cnt + 1) % 32;
        end else if (clear_req_i) begin
            m_clear = 1'b1;
            m_cnt   = 0;
        end else if (WriteEnable) begin
            for (int b = 0; b < 8; b++)
                if (WriteBE[b]) ref_mem[WriteAddr][b*8 +: 8] = WriteData[b*8 +: 8];
            if (WriteBE[0]) corrupt[WriteAddr] = 1'b0;
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.rd)
                $display("rd p%0d data=%h perr=%0d", e.port, ReadData[e.port*64 +: 64], parity_err_o[e.port]);
            check($sformatf("rdata%0d", e.port), ReadData[e.port*64 +: 64], e.data);
            check($sformatf("perr%0d", e.port), 64'(parity_err_o[e.port]), PAR_EN ? 64'(e.perr) : 64'd0);
        end
        check("busy", 64'(clear_busy_o), 64'(m_clear));
    endtask

    // Counts busy cycles from now; optionally raises clear_req_i and random
    // writes at a given cycle to prove they are ignored.
    task automatic count_busy(input int req_at, output int n);
        n = 0;
        while (clear_busy_o === 1'b1 && n < 100) begin
            clear_req_i = (n == req_at);
            WriteEnable = 1'b1;
            WriteAddr   = 5'($urandom_range(0, 31));
            WriteData   = {$urandom, $urandom};
            WriteBE     = 8'hFF;
            step();
            n++;
        end
        clear_req_i = 1'b0;
        WriteEnable = 1'b0;
    endtask

    task automatic read_all();
        ReadEnable = 2'b11;
        for (int a = 0; a < 32; a++) begin
            ReadAddr = {5'(31 - a), 5'(a)};
            step();
        end
        ReadEnable = 2'b00;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            hold_d[p] = '0;
            hold_p[p] = 1'b0;
        end

        // Reset and initial clear.
        #2 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        count_busy(-1, n);
        check("busy_len_reset", 64'(n), 64'd32);
        read_all();

        // Byte-enable merge.
        WriteEnable = 1'b1; WriteAddr = 5'd3; WriteData = 64'h1122334455667788; WriteBE = 8'hFF;
        step();
        WriteData = 64'hAAAAAAAAAAAAAAAA; WriteBE = 8'h0F;
        step();
        WriteEnable = 1'b0; ReadEnable = 2'b01; ReadAddr = {5'd0, 5'd3};
        step();
        check("be_merge", ReadData[63:0], 64'h11223344AAAAAAAA);

        // Write-first forwarding on port 0, old data on port 1.
        WriteEnable = 1'b1; WriteAddr = 5'd8; WriteData = 64'h0123456789ABCDEF; WriteBE = 8'hFF;
        ReadEnable = 2'b00;
        step();
        WriteAddr = 5'd7; WriteData = 64'hDEADBEEF00000000; WriteBE = 8'hF0;
        ReadEnable = 2'b11; ReadAddr = {5'd8, 5'd7};
        step();
        check("fwd_p0", ReadData[63:0], 64'hDEADBEEF00000000);
        check("fwd_p1", ReadData[127:64], 64'h0123456789ABCDEF);

        // Hold when the read strobe is low.
        WriteAddr = 5'd9; WriteData = 64'h55; WriteBE = 8'hFF; ReadEnable = 2'b00;
        step();
        WriteEnable = 1'b0; ReadEnable = 2'b01; ReadAddr = {5'd0, 5'd9};
        step();
        ReadEnable = 2'b00;
        for (int i = 0; i < 3; i++) begin
            ReadAddr = {5'(i), 5'(i + 1)};
            step();
        end
        check("hold", ReadData[63:0], 64'h55);

        // Clear request, writes during the clear, and a second request at cycle 10.
        clear_req_i = 1'b1;
        step();
        clear_req_i = 1'b0;
        count_busy(10, n);
        check("busy_len_req", 64'(n), 64'd32);
        read_all();

        // Reset at clear cycle 5 restarts the full clear.
        WriteEnable = 1'b1; WriteAddr = 5'd4; WriteData = 64'hCAFEF00D12345678; WriteBE = 8'hFF;
        step();
        WriteEnable = 1'b0;
        clear_req_i = 1'b1;
        step();
        clear_req_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_busy(-1, n);
        check("busy_len_rst", 64'(n), 64'd32);
        read_all();

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            WriteEnable = 1'($urandom_range(0, 1));
            WriteAddr   = 5'($urandom_range(0, 31));
            WriteData   = {$urandom, $urandom};
            WriteBE     = 8'($urandom);
            ReadEnable  = 2'($urandom);
            ReadAddr    = ($urandom_range(0, 3) == 0) ? {WriteAddr, WriteAddr} : 10'($urandom);
            clear_req_i = ($urandom_range(0, 59) == 0);
            step();
        end
        clear_req_i = 1'b0;
        WriteEnable = 1'b0;
        while (clear_busy_o === 1'b1 && n < 200) begin
            step();
            n++;
        end

`ifdef REGFILE_PARITY_EN
        // Flip one stored bit of addr 2; port 1 reads a clean entry.
        WriteEnable = 1'b1; WriteAddr = 5'd2; WriteData = 64'h0F0F0F0F0F0F0F0F; WriteBE = 8'hFF;
        ReadEnable = 2'b00;
        step();
        WriteEnable = 1'b0;
        dut.mem[2] = dut.mem[2] ^ 64'h1;
        ref_mem[2] = ref_mem[2] ^ 64'h1;
        corrupt[2] = 1'b1;
        ReadEnable = 2'b11; ReadAddr = {5'd3, 5'd2};
        step();
        check("par_hit", 64'(parity_err_o[0]), 64'd1);
        check("par_clean", 64'(parity_err_o[1]), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
